// File: rtl/ddr100_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : ddr100_cmd_sched
// Brief    : Read/write burst scheduler feeding the DDR PHY strobe paths.
//            It spaces the strobes so that preambles, bursts and turnarounds
//            never overlap.
// Revision : 1.0 - initial release
// ============================================================================
module ddr100_cmd_sched #(
    parameter int WR_SPACING_B8 = 6,
    parameter int WR_SPACING_B4 = 4,
    parameter int RD_SPACING    = 4,
    parameter int WR2RD         = 12,
    parameter int RD2WR         = 4,
    parameter int DRAIN         = 11
) (
    input  logic clk100m,
    input  logic phy_rst,
    input  logic req_valid,
    input  logic req_write,
    input  logic req_burst8,
    output logic req_ready,
    output logic phy_write,
    output logic phy_read,
    output logic phy_burst8,
    output logic inflight
);

    // DRAIN bounds every spacing value, so only the turnarounds can exceed it.
    localparam int c_MAXV = (DRAIN > WR2RD) ? ((DRAIN > RD2WR) ? DRAIN : RD2WR)
                                            : ((WR2RD > RD2WR) ? WR2RD : RD2WR);
    localparam int c_CW   = $clog2(c_MAXV) + 1;

    // A counter loaded with V-1 reaches zero exactly V cycles after the accept.
    localparam logic [c_CW-1:0] c_GAP_WR8 = c_CW'(WR_SPACING_B8 - 1);
    localparam logic [c_CW-1:0] c_GAP_WR4 = c_CW'(WR_SPACING_B4 - 1);
    localparam logic [c_CW-1:0] c_GAP_RD  = c_CW'(RD_SPACING - 1);
    localparam logic [c_CW-1:0] c_WR2RD   = c_CW'(WR2RD - 1);
    localparam logic [c_CW-1:0] c_RD2WR   = c_CW'(RD2WR - 1);
    localparam logic [c_CW-1:0] c_DRAIN   = c_CW'(DRAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_SPACE = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_gap_cnt;
    logic [c_CW-1:0] r_wr2rd_cnt;
    logic [c_CW-1:0] r_rd2wr_cnt;
    logic [c_CW-1:0] r_drain_cnt;
    logic            r_phy_write;
    logic            r_phy_read;
    logic            r_phy_burst8;

    logic            w_turn_ok;
    logic            w_len_ok;
    logic            w_accept;
    logic [c_CW-1:0] w_gap_load;
    logic [c_CW-1:0] w_wr2rd_dec;
    logic [c_CW-1:0] w_rd2wr_dec;
    logic [c_CW-1:0] w_gap_nxt;
    logic [c_CW-1:0] w_wr2rd_nxt;
    logic [c_CW-1:0] w_rd2wr_nxt;
    logic [c_CW-1:0] w_drain_nxt;

    function automatic logic [c_CW-1:0] sat_dec(input logic [c_CW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // SPACE is exactly the set of cycles where the gap counter is nonzero.
    always_comb begin
        w_turn_ok = req_write ? (r_rd2wr_cnt == '0) : (r_wr2rd_cnt == '0);
        w_len_ok  = (req_burst8 == r_phy_burst8) || (r_drain_cnt == '0);
        req_ready = !phy_rst && (r_state != S_SPACE) && w_turn_ok && w_len_ok;
        w_accept  = req_valid && req_ready;
    end

    always_comb begin
        w_gap_load  = req_write ? (req_burst8 ? c_GAP_WR8 : c_GAP_WR4) : c_GAP_RD;
        w_wr2rd_dec = sat_dec(r_wr2rd_cnt);
        w_rd2wr_dec = sat_dec(r_rd2wr_cnt);
        w_gap_nxt   = w_accept ? w_gap_load : sat_dec(r_gap_cnt);
        w_drain_nxt = w_accept ? c_DRAIN : sat_dec(r_drain_cnt);
        w_wr2rd_nxt = (w_accept && req_write && (c_WR2RD > w_wr2rd_dec)) ? c_WR2RD : w_wr2rd_dec;
        w_rd2wr_nxt = (w_accept && !req_write && (c_RD2WR > w_rd2wr_dec)) ? c_RD2WR : w_rd2wr_dec;
    end

    always_ff @(posedge clk100m) begin
        if (phy_rst) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= '0;
            r_wr2rd_cnt  <= '0;
            r_rd2wr_cnt  <= '0;
            r_drain_cnt  <= '0;
            r_phy_write  <= 1'b0;
            r_phy_read   <= 1'b0;
            r_phy_burst8 <= 1'b0;
        end else begin
            r_gap_cnt   <= w_gap_nxt;
            r_wr2rd_cnt <= w_wr2rd_nxt;
            r_rd2wr_cnt <= w_rd2wr_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_phy_write <= w_accept && req_write;
            r_phy_read  <= w_accept && !req_write;
            if (w_accept) begin
                r_phy_burst8 <= req_burst8;
            end
            if (w_gap_nxt != '0) begin
                r_state <= S_SPACE;
            end else if (w_drain_nxt != '0) begin
                r_state <= S_BUSY;
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    // A pulse already queued for the PHY is squashed by the reset that clears the PHY.
    assign phy_write  = r_phy_write && !phy_rst;
    assign phy_read   = r_phy_read && !phy_rst;
    assign phy_burst8 = r_phy_burst8;
    assign inflight   = (r_state != S_IDLE) && !phy_rst;

endmodule
`default_nettype wire

// File: tb/tb_ddr100_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr100_cmd_sched
// Brief    : Directed and randomized bench for ddr100_cmd_sched with a
//            timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr100_cmd_sched;

    localparam int  WR_B8 = 6;
    localparam int  WR_B4 = 4;
    localparam int  RD_SP = 4;
    localparam int  W2R   = 12;
    localparam int  R2W   = 4;
    localparam int  DRN   = 11;
    localparam longint NEVER = -1000;

    logic clk100m = 1'b0;
    logic phy_rst, req_valid, req_write, req_burst8;
    logic req_ready, phy_write, phy_read, phy_burst8, inflight;

    int checks = 0;
    int errors = 0;

    // Model: remembers when the last accepts happened rather than counting down.
    longint cyc = 0;
    longint last_any, last_wr, last_rd;
    int     last_gap;
    bit     m_b8, pend_wr, pend_rd;

    longint wr_times[$];
    longint rd_times[$];
    longint b8_rise;
    bit     seen_ready;

    always #5 clk100m = ~clk100m;

    ddr100_cmd_sched #(
        .WR_SPACING_B8(WR_B8),
        .WR_SPACING_B4(WR_B4),
        .RD_SPACING   (RD_SP),
        .WR2RD        (W2R),
        .RD2WR        (R2W),
        .DRAIN        (DRN)
    ) dut (
        .clk100m   (clk100m),
        .phy_rst   (phy_rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_burst8(req_burst8),
        .req_ready (req_ready),
        .phy_write (phy_write),
        .phy_read  (phy_read),
        .phy_burst8(phy_burst8),
        .inflight  (inflight)
    );

    task automatic model_reset();
        last_any = NEVER;
        last_wr  = NEVER;
        last_rd  = NEVER;
        last_gap = 0;
        m_b8     = 1'b0;
        pend_wr  = 1'b0;
        pend_rd  = 1'b0;
    endtask

    function automatic bit model_ready(bit rst, bit w, bit b8);
        if (rst) return 1'b0;
        if (cyc - last_any < last_gap) return 1'b0;
        if (w && (cyc - last_rd < R2W)) return 1'b0;
        if (!w && (cyc - last_wr < W2R)) return 1'b0;
        if ((b8 != m_b8) && (cyc - last_any < DRN)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive, compare at the falling edge, advance the model.
    task automatic step(bit rst, bit v, bit w, bit b8);
        bit er, acc;
        phy_rst    = rst;
        req_valid  = v;
        req_write  = w;
        req_burst8 = b8;
        @(negedge clk100m);
        er = model_ready(rst, w, b8);
        check("req_ready", req_ready, er);
        check("phy_write", phy_write, pend_wr && !rst);
        check("phy_read", phy_read, pend_rd && !rst);
        check("phy_burst8", phy_burst8, m_b8);
        check("inflight", inflight, !rst && (cyc - last_any < DRN));
        if (phy_write === 1'b1) wr_times.push_back(cyc);
        if (phy_read === 1'b1) rd_times.push_back(cyc);
        if (phy_burst8 === 1'b1 && b8_rise < 0) b8_rise = cyc;
        seen_ready = (req_ready === 1'b1);
        acc = v && er;
        @(posedge clk100m);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            pend_wr = acc && w;
            pend_rd = acc && !w;
            if (acc) begin
                last_any = cyc;
                last_gap = w ? (b8 ? WR_B8 : WR_B4) : RD_SP;
                if (w) last_wr = cyc;
                else   last_rd = cyc;
                m_b8 = b8;
            end
        end
        cyc++;
    endtask

    task automatic start_scenario(output longint base);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        wr_times.delete();
        rd_times.delete();
        b8_rise = -1;
        base    = cyc;
    endtask

    initial begin
        longint base;
        bit rb8;
        model_reset();
        phy_rst    = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_burst8 = 1'b0;
        repeat (2) @(posedge clk100m);
        #1;

        // Reset then idle with fields presented.
        start_scenario(base);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("post_reset_ready", seen_ready, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back BL8 writes.
        start_scenario(base);
        repeat (14) step(1'b0, 1'b1, 1'b1, 1'b1);
        check_int("bl8_wr_count", wr_times.size(), 3);
        if (wr_times.size() == 3) begin
            check_int("bl8_wr_0", wr_times[0] - base, 1);
            check_int("bl8_wr_1", wr_times[1] - base, 7);
            check_int("bl8_wr_2", wr_times[2] - base, 13);
        end

        // Write then read turnaround.
        start_scenario(base);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (14) step(1'b0, 1'b1, 1'b0, 1'b1);
        check_int("w2r_rd_count", rd_times.size(), 1);
        if (rd_times.size() >= 1) check_int("w2r_rd_0", rd_times[0] - base, 13);

        // BL4 write then BL8 write waits for drain.
        start_scenario(base);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b1);
        check_int("drain_wr_count", wr_times.size(), 2);
        if (wr_times.size() == 2) begin
            check_int("drain_wr_0", wr_times[0] - base, 1);
            check_int("drain_wr_1", wr_times[1] - base, 12);
        end
        check_int("drain_b8_rise", b8_rise - base, 12);

        // Read, then write after RD2WR, then read after WR2RD.
        start_scenario(base);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (14) step(1'b0, 1'b1, 1'b0, 1'b0);
        check_int("r2w_wr_count", wr_times.size(), 1);
        if (wr_times.size() >= 1) check_int("r2w_wr_0", wr_times[0] - base, 5);
        check_int("r2w_rd_count", rd_times.size(), 2);
        if (rd_times.size() == 2) begin
            check_int("r2w_rd_0", rd_times[0] - base, 1);
            check_int("r2w_rd_1", rd_times[1] - base, 17);
        end

        // Reset right after a write accept, then restart.
        start_scenario(base);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1);
        check_int("rst_no_pulse", wr_times.size(), 0);
        base = cyc;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        check_int("rst_restart_count", wr_times.size(), 1);
        if (wr_times.size() >= 1) check_int("rst_restart_wr", wr_times[0] - base, 1);

        // Randomized traffic with occasional resets.
        rb8 = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) rb8 = ~rb8;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) < 7),
                 $urandom_range(0, 1) == 1,
                 rb8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
